// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: opcode set,
// loader state encoding and the opcode screening helper.
package imem_loader_pkg;

    typedef enum logic [6:0] {
        ERROR = 7'b0000000,
        LTYPE = 7'b0000011,
        ITYPE = 7'b0010011,
        AUIPC = 7'b0010111,
        STYPE = 7'b0100011,
        RTYPE = 7'b0110011,
        LUI   = 7'b0110111,
        BTYPE = 7'b1100011,
        JALR  = 7'b1100111,
        JTYPE = 7'b1101111
    } opCode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        BYTE   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    localparam int LEN_FIELD_W = 16;

    // ERROR is a reserved encoding, never a legal instruction opcode.
    function automatic logic is_valid_opcode(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            LTYPE, ITYPE, AUIPC, STYPE, RTYPE,
            LUI, BTYPE, JALR, JTYPE: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles little-endian words from a
// byte stream, screens opcodes and releases the core only after a clean load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_WIDTH = $clog2(IMEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_wr_data,
    output logic                  core_rstN,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count,
    output loader_state_t         dbg_state
);

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
    // byte_ready is decoded from the state register alone, never from byte_valid.

    loader_state_t           r_state;
    loader_state_t           w_next_state;
    logic [LEN_FIELD_W-1:0]  r_len;
    logic [1:0]              r_idx;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_count;

    logic                    w_xfer;
    logic [LEN_FIELD_W-1:0]  w_len_full;
    logic                    w_len_oversize;
    logic                    w_len_zero;
    logic                    w_op_ok;
    logic                    w_op_reject;
    logic [ADDR_WIDTH:0]     w_count_inc;
    logic                    w_last_word;

    assign w_xfer         = byte_valid && byte_ready;
    assign w_len_full     = {byte_in, r_len[7:0]};
    assign w_len_oversize = 32'(w_len_full) > 32'(IMEM_DEPTH);
    assign w_len_zero     = (w_len_full == '0);
    assign w_op_ok        = is_valid_opcode(byte_in[6:0]);
    assign w_op_reject    = (r_idx == 2'd0) && !w_op_ok;
    assign w_count_inc    = r_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_last_word    = 32'(w_count_inc) == 32'(r_len);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = LEN_LO;
            end
            LEN_LO: begin
                if (w_xfer) w_next_state = LEN_HI;
            end
            LEN_HI: begin
                if (w_xfer) begin
                    if (w_len_oversize)  w_next_state = ERR;
                    else if (w_len_zero) w_next_state = DONE;
                    else                 w_next_state = BYTE;
                end
            end
            BYTE: begin
                if (w_xfer) begin
                    if (w_op_reject)          w_next_state = ERR;
                    else if (r_idx == 2'd3)   w_next_state = WRITE;
                end
            end
            WRITE: begin
                w_next_state = w_last_word ? DONE : BYTE;
            end
            DONE, ERR: begin
                if (start) w_next_state = LEN_LO;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The write strobe is also gated by rstN so a reset landing on the
    // WRITE cycle suppresses the write instead of letting it through.
    always_comb begin
        byte_ready = 1'b0;
        imem_wr_en = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        core_rstN  = 1'b0;
        case (r_state)
            LEN_LO, LEN_HI, BYTE: byte_ready = 1'b1;
            WRITE:                imem_wr_en = rstN;
            DONE: begin
                done      = 1'b1;
                core_rstN = 1'b1;
            end
            ERR:                  error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_len   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_addr  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_addr  <= '0;
                        r_count <= '0;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) r_len[7:0] <= byte_in;
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= byte_in;
                        r_idx       <= '0;
                    end
                end
                BYTE: begin
                    // A rejected opcode byte is dropped, not shifted in.
                    if (w_xfer && !w_op_reject) begin
                        r_shift <= {byte_in, r_shift[DATA_WIDTH-1:8]};
                        r_idx   <= r_idx + 2'd1;
                    end
                end
                WRITE: begin
                    r_addr  <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    r_count <= w_count_inc;
                end
                default: ;
            endcase
        end
    end

    assign imem_wr_addr = r_addr;
    assign imem_wr_data = r_shift;
    assign word_count   = r_count;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame driver tasks, write scoreboard,
// directed boundary cases and randomised backpressure.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk;
    logic          rstN;
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [DW-1:0] imem_wr_data;
    logic          core_rstN;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;
    loader_state_t dbg_state;

    imem_loader #(.DATA_WIDTH(DW), .IMEM_DEPTH(256), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .core_rstN    (core_rstN),
        .done         (done),
        .error        (error),
        .word_count   (word_count),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    exp_addr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the next queued (addr, data).
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", {32'(imem_wr_addr), imem_wr_data}, 64'h0);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check_val("wr_addr", 64'(imem_wr_addr), 64'(e[AW+DW-1:DW]));
                check_val("wr_data", 64'(imem_wr_data), 64'(e[DW-1:0]));
            end
        end
    end

    // All driver tasks are entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int budget;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        budget     = 50;
        while (!byte_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!byte_ready) check_val("handshake_timeout", 64'(byte_ready), 64'h1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_len(input logic [15:0] n, input int max_gap);
        send_byte(n[7:0], max_gap);
        send_byte(n[15:8], max_gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 1'b1;
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic wait_end();
        int budget;
        budget = 40;
        while (!(done || error) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_val("end_reached", 64'(done | error), 64'h1);
    endtask

    logic [6:0] ops [9];
    logic [31:0] rw;

    initial begin
        ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
        rstN = 1'b0; start = 1'b0; byte_in = '0; byte_valid = 1'b0; exp_addr = '0;

        // Reset
        repeat (2) @(negedge clk);
        check_val("rst_state", 64'(dbg_state), 64'(IDLE));
        check_val("rst_byte_ready", 64'(byte_ready), 64'h0);
        check_val("rst_wr_en", 64'(imem_wr_en), 64'h0);
        check_val("rst_done", 64'(done), 64'h0);
        check_val("rst_error", 64'(error), 64'h0);
        check_val("rst_core_rstN", 64'(core_rstN), 64'h0);
        check_val("rst_addr", 64'(imem_wr_addr), 64'h0);
        check_val("rst_data", 64'(imem_wr_data), 64'h0);
        check_val("rst_count", 64'(word_count), 64'h0);
        rstN = 1'b1;
        byte_in = 8'h13;
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("idle_no_ready", 64'(byte_ready), 64'h0);
            check_val("idle_stays", 64'(dbg_state), 64'(IDLE));
        end
        byte_valid = 1'b0;

        // Normal two-word load, exact timing
        pulse_start();
        check_val("after_start", 64'(dbg_state), 64'(LEN_LO));
        send_len(16'd2, 0);
        send_word(32'h00100513, 0);
        send_word(32'h0000006F, 0);
        check_val("last_write_cycle", 64'(imem_wr_en), 64'h1);
        check_val("no_done_in_write", 64'(done), 64'h0);
        @(negedge clk);
        check_val("norm_done", 64'(done), 64'h1);
        check_val("norm_core_rstN", 64'(core_rstN), 64'h1);
        check_val("norm_error", 64'(error), 64'h0);
        check_val("norm_count", 64'(word_count), 64'd2);
        check_val("norm_addr_after", 64'(imem_wr_addr), 64'd2);
        check_val("norm_q_drained", 64'(exp_q.size()), 64'h0);

        // Empty image
        pulse_start();
        check_val("restart_done_clr", 64'(done), 64'h0);
        check_val("restart_core_rst", 64'(core_rstN), 64'h0);
        check_val("restart_count_clr", 64'(word_count), 64'h0);
        send_len(16'd0, 0);
        check_val("empty_done", 64'(done), 64'h1);
        check_val("empty_core_rstN", 64'(core_rstN), 64'h1);
        check_val("empty_count", 64'(word_count), 64'h0);

        // Bad opcode, then recovery
        pulse_start();
        send_len(16'd1, 0);
        send_byte(8'h7F, 0);
        check_val("badop_error", 64'(error), 64'h1);
        check_val("badop_core_rstN", 64'(core_rstN), 64'h0);
        check_val("badop_ready", 64'(byte_ready), 64'h0);
        check_val("badop_count", 64'(word_count), 64'h0);
        pulse_start();
        check_val("recover_err_clr", 64'(error), 64'h0);
        send_len(16'd1, 0);
        send_word(32'h00000013, 0);
        @(negedge clk);
        check_val("recover_done", 64'(done), 64'h1);
        check_val("recover_count", 64'(word_count), 64'd1);

        // Oversize length
        pulse_start();
        send_len(16'd257, 0);
        check_val("oversize_error", 64'(error), 64'h1);
        check_val("oversize_ready", 64'(byte_ready), 64'h0);

        // Maximum legal length accepted at the length check
        pulse_start();
        send_len(16'd256, 0);
        check_val("maxlen_state", 64'(dbg_state), 64'(BYTE));
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Backpressure: same frame with random gaps
        pulse_start();
        send_len(16'd2, 3);
        send_word(32'h00100513, 3);
        send_word(32'h0000006F, 3);
        wait_end();
        check_val("bp_done", 64'(done), 64'h1);
        check_val("bp_count", 64'(word_count), 64'd2);

        // Longer random image
        pulse_start();
        send_len(16'd6, 2);
        for (int k = 0; k < 6; k++) begin
            rw = $urandom();
            rw[6:0] = ops[$urandom_range(0, 8)];
            send_word(rw, 2);
        end
        wait_end();
        check_val("rand_done", 64'(done), 64'h1);
        check_val("rand_count", 64'(word_count), 64'd6);

        // Reset landing on the WRITE cycle
        pulse_start();
        send_len(16'd1, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        byte_in = 8'h00;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        rstN = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        check_val("abort_in_write", 64'(dbg_state), 64'(WRITE));
        check_val("abort_wr_en", 64'(imem_wr_en), 64'h0);
        @(negedge clk);
        check_val("abort_state", 64'(dbg_state), 64'(IDLE));
        check_val("abort_wr_en2", 64'(imem_wr_en), 64'h0);
        check_val("abort_addr", 64'(imem_wr_addr), 64'h0);
        check_val("abort_data", 64'(imem_wr_data), 64'h0);
        check_val("abort_count", 64'(word_count), 64'h0);
        check_val("abort_core_rstN", 64'(core_rstN), 64'h0);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        check_val("abort_idle_hold", 64'(dbg_state), 64'(IDLE));

        check_val("final_q_empty", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's instruction memory. Accepts a little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. Writes them to consecutive instruction-memory addresses, screening each word's opcode field against the shared opcode set. Holds the core in reset until a load completes cleanly, so instruction fetch only reads a fully written, plausible program image.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; only 32 supported
- IMEM_DEPTH, 256, instruction memory depth in words
- ADDR_WIDTH, $clog2(IMEM_DEPTH), word address width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rstN  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE, ERR
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  loader accepts a byte this cycle
- imem_wr_en  out  1  instruction memory write strobe, one cycle per word
- imem_wr_addr  out  ADDR_WIDTH  word address
- imem_wr_data  out  DATA_WIDTH  assembled word
- core_rstN  out  1  active-low reset to the core; high only in DONE
- done  out  1  load completed successfully
- error  out  1  load aborted
- word_count  out  ADDR_WIDTH+1  words written in current or last load

## Operation
- A byte transfers when byte_valid && byte_ready are both high on a rising edge.
- Frame format:
  - 16-bit word count N, low byte first.
  - Then N words of 4 bytes each, least-significant byte first.
- States:
  - IDLE: start → LEN_LO.
  - LEN_LO: byte accepted → LEN_HI.
  - LEN_HI: byte accepted → check N:
    - N > IMEM_DEPTH → ERR.
    - N == 0 → DONE.
    - otherwise → BYTE.
  - BYTE: 2-bit index counts 0..3.
    - Index 0: byte_in[6:0] is checked against the opcode set: LTYPE, ITYPE, AUIPC, STYPE, RTYPE, LUI, BTYPE, JALR, JTYPE. A mismatch → ERR and the byte is discarded.
    - Accepting index 3 → WRITE.
  - WRITE: imem_wr_en = 1 for exactly one cycle; word_count increments.
    - Address increments after the write.
    - If word_count reaches N → DONE, else → BYTE.
  - DONE: core_rstN = 1, done = 1. start → LEN_LO; this clears done and word_count, resets the address to 0, and drops core_rstN.
  - ERR: error = 1, core_rstN = 0. start → LEN_LO; this clears error and word_count and resets the address to 0.
- byte_ready is 1 only in LEN_LO, LEN_HI and BYTE. It is 0 in WRITE, so there is a one-cycle bubble per word.
- start is ignored in LEN_LO, LEN_HI, BYTE and WRITE.
- imem_wr_addr wraps naturally. Wrap is unreachable because N ≤ IMEM_DEPTH is enforced.

## Timing
- Reset values while rstN = 0 at an edge:
  - state IDLE
  - byte_ready, imem_wr_en, done, error, core_rstN: 0
  - imem_wr_addr, imem_wr_data, word_count: 0
- Reset asserted mid-load aborts immediately. No write occurs in the cycle after reset, even if reset hit in WRITE.
- imem_wr_addr and imem_wr_data are registered and stable in the WRITE cycle. Data is valid the cycle after the 4th byte is accepted.
- done and core_rstN rise the cycle after the last WRITE, or the cycle after LEN_HI when N = 0.
- error rises the cycle after the offending byte is accepted.
- byte_ready is a registered function of state only; it does not depend on byte_valid combinationally.
- Throughput: 5 cycles per word at full input rate.

## Structure
- Additions to the shared definitions package:
  - loader_state_t enum {IDLE, LEN_LO, LEN_HI, BYTE, WRITE, DONE, ERR}
  - function is_valid_opcode(logic [6:0]), built from opCode_t members and excluding ERROR
- No sub-module. Single FSM plus a shift register, byte index, address and count registers.

## Test plan
- Reset: hold rstN = 0 for 2 cycles → all outputs 0, state IDLE; byte_valid = 1 with no start → no handshake.
- Normal load: start, then bytes 02 00 13 05 10 00 6F 00 00 00 →
  - write addr 0 = 0x00100513, then addr 1 = 0x0000006F
  - done = 1, core_rstN = 1, word_count = 2
- Empty image: start, then 00 00 → done = 1 one cycle after the second byte, no imem_wr_en pulse.
- Bad opcode: start, then 01 00 7F → error = 1, no write, core_rstN = 0. Then start and a valid one-word frame → done = 1, write at addr 0.
- Oversize: start, then 01 01 (N = 257, IMEM_DEPTH = 256) → error = 1 after the second byte, byte_ready = 0.
- Backpressure and abort: random byte_valid gaps → identical writes to the normal-load case; rstN = 0 during the WRITE cycle → no write, IDLE, outputs reset.
